imem_boot_ctrl: RTL and testbench

//   Boot sequencer for the single-cycle core.
//   - Streams a program into instruction memory over a valid/ready byte-free word interface.
//   - Verifies a trailing 32-bit checksum word.
//   - On a checksum match, releases the core (PC register + I_Mem read path) from reset.
//   - Returns to a halted state when the core signals halt.
//   - Sits between the host/debug loader and the core's instruction-memory write port and reset.

---
 rtl/imem_boot_ctrl_pkg.sv | 18 +
 rtl/imem_boot_ctrl_if.sv | 28 ++
 rtl/imem_boot_ctrl_checksum.sv | 29 ++
 rtl/imem_boot_ctrl.sv | 109 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot sequencer.
// Imported by the controller, its checksum unit and the loader interface.
package imem_boot_ctrl_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD   = 3'd1;
    localparam state_t S_CHECK  = 3'd2;
    localparam state_t S_RUN    = 3'd3;
    localparam state_t S_HALTED = 3'd4;
    localparam state_t S_ERROR  = 3'd5;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader-to-controller word stream: valid/ready with a last-word marker.
// The host drives the master side, the boot controller the slave side.
interface imem_boot_ctrl_if
    import imem_boot_ctrl_pkg::*;
#(
    parameter int DW = DATA_W
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/imem_boot_ctrl_checksum.sv
// Modulo-2^W running sum of program words with clear/enable and a
// combinational compare against the incoming checksum word.
module boot_checksum
    import imem_boot_ctrl_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum,
    output logic         match
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

    assign match = (din == sum);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program into instruction memory, verifies the
// trailing checksum and releases the core from reset on a match.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int DEPTH  = imem_boot_ctrl_pkg::DEPTH,
    parameter int ADDR_W = imem_boot_ctrl_pkg::ADDR_W,
    parameter int DATA_W = imem_boot_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    imem_boot_ctrl_if.slave   ld,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    input  logic              core_halt,
    output logic              busy,
    output logic              running,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            nxt;
    logic              ready;
    logic              xfer;
    logic              start_ok;
    logic              add;
    logic              match;
    logic [DATA_W-1:0] sum;

    assign ld.in_ready = ready;
    assign xfer        = ld.in_valid && ready;
    assign start_ok    = load_start && (state != S_LOAD) && (state != S_CHECK);
    assign add         = xfer && (state == S_LOAD);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (load_start) nxt = S_LOAD;
            end
            S_RUN: begin
                if (load_start)     nxt = S_LOAD;
                else if (core_halt) nxt = S_HALTED;
            end
            S_LOAD: begin
                if (xfer) begin
                    if (ld.in_last)                    nxt = S_CHECK;
                    else if (word_count == LAST_ADDR)  nxt = S_ERROR;
                end
            end
            S_CHECK: begin
                if (xfer) nxt = match ? S_RUN : S_ERROR;
            end
            default: nxt = S_IDLE;
        endcase
    end

    boot_checksum #(.W(DATA_W)) u_sum (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (add),
        .din   (ld.in_data),
        .sum   (sum),
        .match (match)
    );

    // Status outputs are decoded from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            running    <= 1'b0;
            core_reset <= 1'b1;
            error      <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_count <= '0;
        end else begin
            state      <= nxt;
            ready      <= (nxt == S_LOAD) || (nxt == S_CHECK);
            busy       <= (nxt == S_LOAD) || (nxt == S_CHECK);
            running    <= (nxt == S_RUN);
            core_reset <= (nxt != S_RUN);
            error      <= (nxt == S_ERROR);
            imem_we    <= add;
            if (add) begin
                imem_waddr <= word_count[ADDR_W-1:0];
                imem_wdata <= ld.in_data;
            end
            if (start_ok) begin
                word_count <= '0;
            end else if (add && (word_count != MAX_COUNT)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard.
module tb_imem_boot_ctrl;
    import imem_boot_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        core_halt = 1'b0;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        running;
    logic        error;
    logic [6:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [37:0] sb[$];
    logic [5:0]  exp_addr;
    logic [31:0] exp_sum;

    imem_boot_ctrl_if ld ();

    imem_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .ld         (ld.slave),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .core_halt  (core_halt),
        .busy       (busy),
        .running    (running),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [37:0] e;
        if (imem_we) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_write obs=%0d:%h exp=none",
                       imem_waddr, imem_wdata);
            end else begin
                e = sb.pop_front();
                assert ({imem_waddr, imem_wdata} === e) else begin
                    n_err++;
                    $error("FAIL write obs=%0d:%h exp=%0d:%h",
                           imem_waddr, imem_wdata, e[37:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        exp_addr = '0;
        exp_sum  = '0;
    endtask

    // prog=1: program word (scoreboarded, summed); prog=0: checksum word
    task automatic xfer(input logic [31:0] d, input logic last,
                        input bit prog);
        int n = 0;
        ld.in_valid = 1'b1;
        ld.in_data  = d;
        ld.in_last  = last;
        while (ld.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, ld.in_ready}, 32'd1);
        if (prog) begin
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 6'd1;
            exp_sum  = exp_sum + d;
        end
        @(negedge clk);
        ld.in_valid = 1'b0;
        ld.in_data  = $urandom;
        ld.in_last  = 1'b0;
    endtask

    task automatic load3(input logic [31:0] cks_xor);
        pulse_start();
        xfer(32'h0050_0093, 1'b0, 1);
        xfer(32'h0010_8113, 1'b0, 1);
        xfer(32'h0000_0073, 1'b1, 1);
        xfer(exp_sum ^ cks_xor, 1'b0, 0);
    endtask

    initial begin
        ld.in_valid = 1'b0;
        ld.in_data  = '0;
        ld.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_ready", {31'b0, ld.in_ready}, 32'd0);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_count", {25'b0, word_count}, 32'd0);
        chk("rst_waddr", {26'b0, imem_waddr}, 32'd0);
        reset = 1'b0;

        ld.in_valid = 1'b1;
        ld.in_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        ld.in_valid = 1'b0;
        chk("idle_count", {25'b0, word_count}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        load3(32'h0);
        chk("good_running", {31'b0, running}, 32'd1);
        chk("good_core_reset", {31'b0, core_reset}, 32'd0);
        chk("good_count", {25'b0, word_count}, 32'd3);
        chk("good_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("good_hold", {31'b0, running}, 32'd1);

        load3(32'hFFFF_FFFF);
        chk("bad_error", {31'b0, error}, 32'd1);
        chk("bad_core_reset", {31'b0, core_reset}, 32'd1);
        chk("bad_running", {31'b0, running}, 32'd0);
        pulse_start();
        chk("restart_error", {31'b0, error}, 32'd0);
        chk("restart_busy", {31'b0, busy}, 32'd1);

        for (int i = 0; i < 64; i++) xfer(32'h1000_0000 + i, 1'b0, 1);
        chk("ovf_error", {31'b0, error}, 32'd1);
        chk("ovf_ready", {31'b0, ld.in_ready}, 32'd0);
        chk("ovf_count", {25'b0, word_count}, 32'd64);
        @(negedge clk);
        chk("ovf_drain", sb.size(), 32'd0);

        pulse_start();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer($urandom, (i == 9), 1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        xfer(exp_sum, 1'b0, 0);
        chk("bp_running", {31'b0, running}, 32'd1);
        chk("bp_count", {25'b0, word_count}, 32'd10);

        core_halt = 1'b1;
        @(negedge clk);
        core_halt = 1'b0;
        chk("halt_core_reset", {31'b0, core_reset}, 32'd1);
        chk("halt_running", {31'b0, running}, 32'd0);
        chk("halt_error", {31'b0, error}, 32'd0);
        chk("halt_busy", {31'b0, busy}, 32'd0);

        load3(32'h0);
        chk("rerun_running", {31'b0, running}, 32'd1);
        core_halt = 1'b1;
        pulse_start();
        core_halt = 1'b0;
        chk("start_wins_busy", {31'b0, busy}, 32'd1);
        chk("start_wins_core_reset", {31'b0, core_reset}, 32'd1);
        chk("start_wins_count", {25'b0, word_count}, 32'd0);

        for (int i = 0; i < 5; i++) xfer(32'hA000_0000 + i, 1'b0, 1);
        ld.in_valid = 1'b1;
        ld.in_data  = 32'hA000_0005;
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, ld.in_ready}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_count", {25'b0, word_count}, 32'd0);
        chk("midrst_core_reset", {31'b0, core_reset}, 32'd1);
        ld.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_idle", {31'b0, busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
